// File: rtl/nd_2to1_arb.sv
// nd_2to1_arb: round-robin merge of two 4-phase req/ack message channels
// onto one outbound channel. One message is latched per grant. The inbound
// and outbound handshakes then complete independently, and per-input grant
// counters are kept for debug.
//
// state | meaning
// IDLE  | no message held; picks the next eligible input
// XFER  | message latched; inbound ack and outbound req retire independently
// DRAIN | both handshakes retired; waiting for o0_ack to fall before counting

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif

module nd_2to1_arb #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int CSZ = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i0_req,
  output logic           i0_ack,
  input  logic [ASZ-1:0] i0_src,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [ASZ-1:0] i0_dst,
  input  logic           i1_req,
  output logic           i1_ack,
  input  logic [ASZ-1:0] i1_src,
  input  logic [DSZ-1:0] i1_dat,
  input  logic [ASZ-1:0] i1_dst,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [DSZ-1:0] o0_dat,
  output logic [ASZ-1:0] o0_dst,
  output logic [CSZ-1:0] o_cnt_0,
  output logic [CSZ-1:0] o_cnt_1,
  output logic           o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic           sel_q, sel_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           oreq_q, oreq_d;
  logic [ASZ-1:0] src_q, src_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic [ASZ-1:0] dst_q, dst_d;
  logic [CSZ-1:0] cnt0_q, cnt0_d;
  logic [CSZ-1:0] cnt1_q, cnt1_d;

  logic el0, el1;
  logic gnt_any, gnt_sel;
  logic sel_req, sel_ack, ack_keep;

  // Next-state, grant selection and handshake retirement.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sel_d    = sel_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    oreq_d   = oreq_q;
    src_d    = src_q;
    dat_d    = dat_q;
    dst_d    = dst_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    el0      = i0_req && !ack0_q && !o0_ack;
    el1      = i1_req && !ack1_q && !o0_ack;
    gnt_any  = el0 || el1;
    // On a tie, the input that was not granted last time wins.
    gnt_sel  = (el0 && el1) ? ~last_q : el1;
    sel_req  = sel_q ? i1_req : i0_req;
    sel_ack  = sel_q ? ack1_q : ack0_q;
    ack_keep = sel_ack && sel_req;

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          sel_d   = gnt_sel;
          last_d  = gnt_sel;
          oreq_d  = 1'b1;
          state_d = ST_XFER;
          if (gnt_sel) begin
            ack1_d = 1'b1;
            src_d  = i1_src;
            dat_d  = i1_dat;
            dst_d  = i1_dst;
          end else begin
            ack0_d = 1'b1;
            src_d  = i0_src;
            dat_d  = i0_dat;
            dst_d  = i0_dst;
          end
        end
      end
      ST_XFER: begin
        if (sel_ack && !sel_req) begin
          if (sel_q) ack1_d = 1'b0;
          else       ack0_d = 1'b0;
        end
        if (oreq_q && o0_ack) oreq_d = 1'b0;
        if (!ack_keep && !oreq_d) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!o0_ack) begin
          if (sel_q) cnt1_d = cnt1_q + CSZ'(1);
          else       cnt0_d = cnt0_q + CSZ'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      oreq_q  <= 1'b0;
      src_q   <= '0;
      dat_q   <= '0;
      dst_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      oreq_q  <= oreq_d;
      src_q   <= src_d;
      dat_q   <= dat_d;
      dst_q   <= dst_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign i0_ack  = ack0_q;
  assign i1_ack  = ack1_q;
  assign o0_req  = oreq_q;
  assign o0_src  = src_q;
  assign o0_dat  = dat_q;
  assign o0_dst  = dst_q;
  assign o_cnt_0 = cnt0_q;
  assign o_cnt_1 = cnt1_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nd_2to1_arb.sv
// Directed bench for nd_2to1_arb: inputs are driven and outputs sampled on
// the falling clock edge.

module tb_nd_2to1_arb;

  logic       i_clk;
  logic       i_rst_n;
  logic       i0_req, i1_req;
  logic       i0_ack, i1_ack;
  logic [7:0] i0_src, i0_dat, i0_dst;
  logic [7:0] i1_src, i1_dat, i1_dst;
  logic       o0_req;
  logic       o0_ack;
  logic [7:0] o0_src, o0_dat, o0_dst;
  logic [7:0] o_cnt_0, o_cnt_1;
  logic       o_busy;

  logic       inst_resp;
  logic       o0_ack_man;

  int checks;
  int failures;

  assign o0_ack = inst_resp ? o0_req : o0_ack_man;

  nd_2to1_arb #(.ASZ(8), .DSZ(8), .CSZ(8)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i0_req  (i0_req),
    .i0_ack  (i0_ack),
    .i0_src  (i0_src),
    .i0_dat  (i0_dat),
    .i0_dst  (i0_dst),
    .i1_req  (i1_req),
    .i1_ack  (i1_ack),
    .i1_src  (i1_src),
    .i1_dat  (i1_dat),
    .i1_dst  (i1_dst),
    .o0_req  (o0_req),
    .o0_ack  (o0_ack),
    .o0_src  (o0_src),
    .o0_dat  (o0_dat),
    .o0_dst  (o0_dst),
    .o_cnt_0 (o_cnt_0),
    .o_cnt_1 (o_cnt_1),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i0_req = 1'b0; i1_req = 1'b0;
    i0_src = '0; i0_dat = '0; i0_dst = '0;
    i1_src = '0; i1_dat = '0; i1_dst = '0;
    inst_resp = 1'b0; o0_ack_man = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    inst_resp = 1'b0; o0_ack_man = 1'b0;
    i0_req = 1'b1; i0_src = 8'h11; i0_dat = 8'hA5; i0_dst = 8'h22;
    i1_req = 1'b0; i1_src = '0; i1_dat = '0; i1_dst = '0;
    step();
    checks++;
    if ({i0_ack, i1_ack, o0_req, o_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got ack0/ack1/req/busy=%b want 0000", {i0_ack, i1_ack, o0_req, o_busy});
    end
    checks++;
    if ({o0_src, o0_dat, o0_dst, o_cnt_0, o_cnt_1} !== 40'h0) begin
      failures++;
      $display("FAIL reset_data got %h want 0", {o0_src, o0_dat, o0_dst, o_cnt_0, o_cnt_1});
    end
    i_rst_n = 1'b1;
    step();
    checks++;
    if ({i0_ack, o0_req} !== 2'b11) begin
      failures++;
      $display("FAIL reset_release_grant got ack0/req=%b want 11", {i0_ack, o0_req});
    end
    checks++;
    if (o0_dat !== 8'hA5) begin
      failures++;
      $display("FAIL reset_release_dat got %h want a5", o0_dat);
    end
  endtask

  task automatic test_single();
    do_reset();
    i0_src = 8'd1; i0_dat = 8'd5; i0_dst = 8'd3; i0_req = 1'b1;
    step();
    checks++;
    if ({o0_req, i0_ack, i1_ack, o_busy} !== 4'b1101) begin
      failures++;
      $display("FAIL single_grant got req/ack0/ack1/busy=%b want 1101", {o0_req, i0_ack, i1_ack, o_busy});
    end
    checks++;
    if ({o0_src, o0_dat, o0_dst} !== {8'd1, 8'd5, 8'd3}) begin
      failures++;
      $display("FAIL single_msg got src=%0d dat=%0d dst=%0d want 1 5 3", o0_src, o0_dat, o0_dst);
    end
    i0_req = 1'b0; o0_ack_man = 1'b1;
    step();
    o0_ack_man = 1'b0;
    step();
    checks++;
    if ({o_cnt_0, o_cnt_1, 7'd0, o0_req} !== {8'd1, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL single_done got cnt0=%0d cnt1=%0d req=%b want 1 0 0", o_cnt_0, o_cnt_1, o0_req);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] exp0, exp1, sent0, sent1;
    logic       exp_id, prev;
    int         got;
    do_reset();
    inst_resp = 1'b1;
    i0_src = 8'd0; i1_src = 8'd1; i0_dst = 8'd7; i1_dst = 8'd7;
    i0_dat = 8'd0; i1_dat = 8'd0; i0_req = 1'b1; i1_req = 1'b1;
    sent0 = 8'd1; sent1 = 8'd1; exp0 = 8'd0; exp1 = 8'd0;
    exp_id = 1'b0; prev = 1'b0; got = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      if (o0_req && !prev) begin
        got++;
        checks++;
        if (o0_src !== {7'd0, exp_id}) begin
          failures++;
          $display("FAIL alt_order grant %0d got src=%0d want %0d", got, o0_src, exp_id);
        end
        checks++;
        if (o0_dat !== (exp_id ? exp1 : exp0)) begin
          failures++;
          $display("FAIL alt_data grant %0d got dat=%0d want %0d", got, o0_dat, exp_id ? exp1 : exp0);
        end
        if (o0_src == 8'd1) exp1 = exp1 + 8'd1;
        else                exp0 = exp0 + 8'd1;
        exp_id = ~exp_id;
      end
      prev = o0_req;
      if (i0_req && i0_ack) i0_req = 1'b0;
      else if (!i0_req && !i0_ack && sent0 < 8'd16) begin
        i0_dat = sent0; i0_req = 1'b1; sent0 = sent0 + 8'd1;
      end
      if (i1_req && i1_ack) i1_req = 1'b0;
      else if (!i1_req && !i1_ack && sent1 < 8'd16) begin
        i1_dat = sent1; i1_req = 1'b1; sent1 = sent1 + 8'd1;
      end
      if (o_cnt_0 == 8'd16 && o_cnt_1 == 8'd16) break;
    end
    checks++;
    if (got != 32) begin
      failures++;
      $display("FAIL alt_total got %0d grants want 32", got);
    end
    checks++;
    if ({o_cnt_0, o_cnt_1} !== {8'd16, 8'd16}) begin
      failures++;
      $display("FAIL alt_counts got cnt0=%0d cnt1=%0d want 16 16", o_cnt_0, o_cnt_1);
    end
    inst_resp = 1'b0;
  endtask

  task automatic test_slow_out();
    do_reset();
    i1_src = 8'd9; i1_dat = 8'h33; i1_dst = 8'd4; i1_req = 1'b1;
    step();
    checks++;
    if ({i1_ack, o0_req, o0_dat} !== {1'b1, 1'b1, 8'h33}) begin
      failures++;
      $display("FAIL slow_grant got ack1=%b req=%b dat=%h want 1 1 33", i1_ack, o0_req, o0_dat);
    end
    i1_req = 1'b0;
    i0_src = 8'd8; i0_dat = 8'h44; i0_dst = 8'd2; i0_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({i1_ack, i0_ack, o0_req, o0_dat} !== {1'b0, 1'b0, 1'b1, 8'h33}) begin
        failures++;
        $display("FAIL slow_hold cyc %0d got ack1=%b ack0=%b req=%b dat=%h want 0 0 1 33", k, i1_ack, i0_ack, o0_req, o0_dat);
      end
    end
    o0_ack_man = 1'b1;
    step();
    checks++;
    if ({o0_req, i0_ack, o_busy, o0_dat} !== {1'b0, 1'b0, 1'b1, 8'h33}) begin
      failures++;
      $display("FAIL slow_oack got req=%b ack0=%b busy=%b dat=%h want 0 0 1 33", o0_req, i0_ack, o_busy, o0_dat);
    end
    step();
    checks++;
    if ({i0_ack, o_busy, o_cnt_1} !== {1'b0, 1'b1, 8'd0}) begin
      failures++;
      $display("FAIL slow_drain got ack0=%b busy=%b cnt1=%0d want 0 1 0", i0_ack, o_busy, o_cnt_1);
    end
    o0_ack_man = 1'b0;
    step();
    checks++;
    if ({i0_ack, o_busy, o_cnt_1} !== {1'b0, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL slow_done got ack0=%b busy=%b cnt1=%0d want 0 0 1", i0_ack, o_busy, o_cnt_1);
    end
    step();
    checks++;
    if ({i0_ack, o0_dat, o0_src} !== {1'b1, 8'h44, 8'd8}) begin
      failures++;
      $display("FAIL slow_next got ack0=%b dat=%h src=%0d want 1 44 8", i0_ack, o0_dat, o0_src);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i0_dat = 8'h5A; i0_req = 1'b1;
    step();
    checks++;
    if ({o0_req, i0_ack} !== 2'b11) begin
      failures++;
      $display("FAIL mid_grant got req/ack0=%b want 11", {o0_req, i0_ack});
    end
    i_rst_n = 1'b0; o0_ack_man = 1'b1;
    step();
    checks++;
    if ({o0_req, i0_ack, i1_ack, o_busy, o_cnt_0, o_cnt_1, o0_dat} !== 28'h0) begin
      failures++;
      $display("FAIL mid_reset got req=%b ack0=%b ack1=%b busy=%b cnt0=%0d cnt1=%0d dat=%h want all 0", o0_req, i0_ack, i1_ack, o_busy, o_cnt_0, o_cnt_1, o0_dat);
    end
    i_rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({i0_ack, o0_req, o_busy} !== 3'b000) begin
        failures++;
        $display("FAIL mid_block cyc %0d got ack0/req/busy=%b want 000", k, {i0_ack, o0_req, o_busy});
      end
    end
    o0_ack_man = 1'b0;
    step();
    checks++;
    if ({i0_ack, o0_req, o0_dat, o_cnt_0} !== {1'b1, 1'b1, 8'h5A, 8'd0}) begin
      failures++;
      $display("FAIL mid_regrant got ack0=%b req=%b dat=%h cnt0=%0d want 1 1 5a 0", i0_ack, o0_req, o0_dat, o_cnt_0);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] exp_cnt;
    do_reset();
    i1_src = 8'd1; i1_dst = 8'd2;
    exp_cnt = 8'd0;
    for (int n = 0; n < 256; n++) begin
      i1_dat = 8'(n);
      i1_req = 1'b1;
      step();
      checks++;
      if ({i1_ack, o0_req, o0_dat} !== {1'b1, 1'b1, 8'(n)}) begin
        failures++;
        $display("FAIL wrap_grant n=%0d got ack1=%b req=%b dat=%h want 1 1 %h", n, i1_ack, o0_req, o0_dat, 8'(n));
      end
      i1_req = 1'b0; o0_ack_man = 1'b1;
      step();
      o0_ack_man = 1'b0;
      step();
      exp_cnt = exp_cnt + 8'd1;
      checks++;
      if ({o_cnt_1, o_cnt_0} !== {exp_cnt, 8'd0}) begin
        failures++;
        $display("FAIL wrap_count n=%0d got cnt1=%0d cnt0=%0d want %0d 0", n, o_cnt_1, o_cnt_0, exp_cnt);
      end
    end
    checks++;
    if ({o_cnt_1, o_cnt_0} !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_final got cnt1=%0d cnt0=%0d want 0 0", o_cnt_1, o_cnt_0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_alternate();
    test_slow_out();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nd_2to1_arb.md
# nd_2to1_arb

Round-robin merge arbiter sharing one outbound message channel between two inbound channels, all using the codebase's 4-phase req/ack protocol with src/dat/dst message fields. It is the converging counterpart to the 1-to-2 routing node: it sits where two message streams must funnel into a single downstream link. It latches one message per grant and runs the inbound and outbound handshakes concurrently. It also keeps per-input grant counters for debug.

## Interface
- ASZ, `NS_ADDRESS_SIZE: width of src and dst fields
- DSZ, `NS_DATA_SIZE: width of dat field
- CSZ, 8: width of grant counters
- i_clk  in  1  main clock
- i_rst_n  in  1  reset, synchronous, active-low; one clock, no other clock domains
- i0_req / i1_req  in  1  inbound request, inputs 0 and 1
- i0_ack / i1_ack  out  1  inbound acknowledge
- i0_src, i1_src  in  ASZ; i0_dat, i1_dat  in  DSZ; i0_dst, i1_dst  in  ASZ  inbound message
- o0_req  out  1  outbound request
- o0_ack  in  1  outbound acknowledge
- o0_src  out  ASZ; o0_dat  out  DSZ; o0_dst  out  ASZ  outbound message
- o_cnt_0, o_cnt_1  out  CSZ  completed grants per input
- o_busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, XFER, DRAIN.
- Round-robin pointer r_last (1 bit) holds the last granted input. Reset value is 1, so input 0 wins the first tie.
- IDLE grant rule:
  - Candidate k is eligible when ik_req=1, ik_ack=0 and o0_ack=0.
  - If both inputs are eligible, grant the one != r_last.
  - If one is eligible, grant it.
  - On grant: latch ik_src/dat/dst into the output message registers, set r_sel=k, r_last=k, ik_ack<=1, o0_req<=1, and go to XFER.
- XFER: the two sides run independently.
  - Inbound side: when i{r_sel}_req=0 and i{r_sel}_ack=1, set ack<=0.
  - Outbound side: when o0_req=1 and o0_ack=1, set o0_req<=0.
  - When both ack and o0_req are 0 (or will be 0 after this edge), go to DRAIN.
- DRAIN: wait for o0_ack=0. On that edge, increment o_cnt_{r_sel} (wraps modulo 2^CSZ) and go to IDLE.
- The non-granted input's ack stays 0 throughout. Its request stays pending and is served on a later grant.
- Output message registers change only on a grant. They are stable while o0_req=1.
- At most one message is in flight. No grant is issued outside IDLE.
- Reset values: all acks 0, o0_req 0, o0_src/dat/dst 0, counters 0, o_busy 0, state IDLE, r_last 1, r_sel 0.
- Reset mid-transfer: all outputs return to reset values at the first edge with i_rst_n=0. The in-flight message is dropped and not counted.
- After reset deasserts, a still-high o0_ack blocks grants until it drops. A still-high ik_req is granted normally.

## Timing
- Grant latency: 1 cycle. If ik_req rises before edge N, then ik_ack and o0_req are high after edge N.
- Inbound ack falls 1 cycle after its req is seen low. Outbound req falls 1 cycle after o0_ack is seen high.
- Minimum grant-to-grant spacing is 3 cycles: grant edge, XFER exit edge, DRAIN exit edge. This assumes responders that answer in zero cycles.
- Counter updates at the DRAIN exit edge. o_busy follows the registered state, with no combinational paths from inputs to outputs.
- Simultaneous requests alternate grants strictly: 0, 1, 0, 1...
- A single requester is granted back-to-back with no penalty.

## Test plan
- Reset while i0_req=1 and o0_ack=0 → all outputs 0. One cycle after i_rst_n rises, i0_ack=1, o0_req=1 and o0_dat equals i0_dat.
- i0 only, dat=5, dst=3, src=1 → o0 carries src=1, dat=5, dst=3. After the responder's ack drops: o_cnt_0=1, o_cnt_1=0, o0_req=0.
- i0 and i1 held high continuously, dat 0..15 each side, instant responder → grants alternate 0,1,0,1 starting with 0. After 32 messages: o_cnt_0=16 and o_cnt_1=16, each stream arrives in order, and no message is lost or duplicated.
- Slow outbound responder (o0_ack rises 5 cycles after o0_req) with fast i1 → i1_ack drops early, o0_dat holds stable until o0_ack, and no new grant occurs before o0_ack=0.
- Reset asserted during XFER → next cycle o0_req=0, acks 0, counters 0. Reset released with o0_ack=1 → no grant until o0_ack=0.
- 256 grants on i1 with CSZ=8 → o_cnt_1 wraps to 0 and o_cnt_0 stays 0.
